// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl
//
// Read-side pointer controller for a dual-clock FIFO. It brings the Gray-coded
// write pointer into the read clock domain through a plain flop synchronizer
// and converts it back to binary. It keeps the read pointer in binary and Gray
// form, and produces the memory read strobe and address, the empty flag, the
// occupancy level and an underflow pulse.
//
// Ports
//   clk            read-domain clock, rising edge
//   rst_n          asynchronous active-low reset (release synchronized upstream)
//   wr_ptr_gray_i  Gray write pointer from the write domain (asynchronous)
//   rd_req         consumer asks for one word this cycle
//   rd_en          memory read strobe, rd_req && !empty (combinational)
//   rd_addr        registered memory read address (low bits of read pointer)
//   rd_ptr_gray    registered Gray read pointer, sent to the write domain
//   empty          registered, high when no word is readable
//   rd_level       registered word count, 0 .. 2**ADDR_WIDTH
//   underflow      registered one-cycle pulse for a rejected read request
module fifo_rd_ptr_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_i,
    input  logic                  rd_req,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);

    // Pointer width: one extra wrap bit distinguishes full from empty.
    localparam int PW = ADDR_WIDTH + 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("fifo_rd_ptr_ctrl: SYNC_STAGES must be at least 2");
    end

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchronizer chain, stage 0 first; pure shift, nothing between stages.
    logic [SYNC_STAGES-1:0][PW-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0][PW-1:0] wr_sync_d;

    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] wr_bin_s;

    logic [PW-1:0] rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0] rd_ptr_gray_q, rd_ptr_gray_d;
    logic          empty_q, empty_d;
    logic [PW-1:0] rd_level_q, rd_level_d;
    logic          underflow_q, underflow_d;

    always_comb begin
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], wr_ptr_gray_i};
    end

    assign wr_gray_s = wr_sync_q[SYNC_STAGES-1];
    assign wr_bin_s  = gray2bin(wr_gray_s);

    // A read is only granted while the registered flag says data is present.
    assign rd_en = rd_req && !empty_q;

    always_comb begin
        rd_ptr_bin_d  = rd_ptr_bin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
        rd_ptr_gray_d = bin2gray(rd_ptr_bin_d);
        // Comparing the post-read pointer lets empty rise on the very edge
        // that consumes the last word, so no extra read can get through.
        empty_d       = (rd_ptr_gray_d == wr_gray_s);
        // Modular subtraction stays correct across the pointer wrap.
        rd_level_d    = wr_bin_s - rd_ptr_bin_d;
        underflow_d   = rd_req && empty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q     <= '0;
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            empty_q       <= 1'b1;
            rd_level_q    <= '0;
            underflow_q   <= 1'b0;
        end else begin
            wr_sync_q     <= wr_sync_d;
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            empty_q       <= empty_d;
            rd_level_q    <= rd_level_d;
            underflow_q   <= underflow_d;
        end
    end

    // rd_ptr_gray crosses into the write domain, so it comes straight off a flop.
    assign rd_addr     = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign rd_ptr_gray = rd_ptr_gray_q;
    assign empty       = empty_q;
    assign rd_level    = rd_level_q;
    assign underflow   = underflow_q;

endmodule

// File: doc/fifo_rd_ptr_ctrl.md
# fifo_rd_ptr_ctrl

Read-side pointer controller for the dual-clock FIFO. It consumes the Gray-coded write pointer produced by the write-side binary-to-Gray stage, synchronizes it into the read clock domain and converts it back to binary. It maintains the read pointer in both binary and Gray form and generates the memory read address and enable, the empty flag, the occupancy level and an underflow pulse. It sits directly downstream of the write domain's binary-to-Gray pointer conversion.

## Interface
- ADDR_WIDTH, default 4: FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide, the extra MSB being the wrap bit.
- SYNC_STAGES, default 2: flop stages in the write-pointer synchronizer; legal values are ≥ 2.

- clk  input  1  read-domain clock; all flops are rising-edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous and release is synchronous to clk (release is synchronized externally).
- wr_ptr_gray_i  input  ADDR_WIDTH+1  Gray write pointer from the write domain; asynchronous to clk; changes at most one bit per write-clock cycle.
- rd_req  input  1  consumer requests one word this cycle.
- rd_en  output  1  combinational: rd_req && !empty; memory read strobe.
- rd_addr  output  ADDR_WIDTH  rd_ptr_bin[ADDR_WIDTH-1:0]; registered.
- rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- empty  output  1  registered; high when there is no readable word.
- rd_level  output  ADDR_WIDTH+1  registered word count, range 0..2^ADDR_WIDTH.
- underflow  output  1  registered one-cycle pulse flagging a rejected read.

## Operation
- Synchronizer: a chain of SYNC_STAGES flops on wr_ptr_gray_i, producing wr_gray_s. No logic is allowed between stages.
- Gray-to-binary: wr_bin_s[MSB] = wr_gray_s[MSB]; wr_bin_s[i] = wr_bin_s[i+1] ^ wr_gray_s[i]. This path is combinational from the last sync stage.
- Internal register rd_ptr_bin, ADDR_WIDTH+1 bits:
  - rd_ptr_bin_next = rd_ptr_bin + rd_en, wrapping modulo 2^(ADDR_WIDTH+1).
  - rd_ptr_gray <= rd_ptr_bin_next ^ (rd_ptr_bin_next >> 1), updated on the same edge as rd_ptr_bin.
- Empty flag:
  - empty <= (rd_ptr_bin_next ^ (rd_ptr_bin_next >> 1)) == wr_gray_s.
  - Because the next pointer is used, empty asserts on the same edge that consumes the last word. No extra read can slip through.
- Level: rd_level <= (wr_bin_s - rd_ptr_bin_next) mod 2^(ADDR_WIDTH+1).
- Underflow:
  - underflow <= rd_req && empty.
  - A rejected request does not move the pointer, does not assert rd_en, and does not alter the level.
- There is no state machine. All state is held in the pointer, synchronizer, flag and level registers.

## Timing
- Reset values (async assert):
  - Sync stages: 0.
  - rd_ptr_bin: 0, so rd_addr = 0.
  - rd_ptr_gray: 0.
  - empty: 1.
  - rd_level: 0.
  - underflow: 0.
  - rd_en follows combinationally and is 0 while empty.
- Write-to-visible latency: a wr_ptr_gray_i change stable before edge N appears in wr_gray_s after edge N+SYNC_STAGES-1. empty and rd_level reflect it after edge N+SYNC_STAGES, which is 3 edges for the default.
- Read latency:
  - rd_en is sampled at edge E.
  - rd_addr, rd_ptr_gray, empty and rd_level all update at edge E.
  - Memory data for the address presented before E is the memory's concern, not this block's.
- Simultaneous events: a read and a sync-chain update on the same edge are handled by using rd_ptr_bin_next and the current wr_gray_s together. The level is the net of both; empty is exact.
- Wrap-around: the pointer wraps from 2^(ADDR_WIDTH+1)-1 to 0 with a single Gray bit change. Level arithmetic is modular and stays correct across the wrap.
- Full (level = 2^ADDR_WIDTH): this is legal and reported as is. Full detection is not this block's job.
- Reset mid-operation: all registers return to their reset values immediately. A read in flight is dropped and underflow does not fire.
- rd_ptr_gray is driven straight from a flop, with no combinational logic on the output, because it crosses clock domains.

## Test plan
- Reset: hold rst_n = 0, then drive wr_ptr_gray_i = 0x03 -> all outputs stay at their reset values (empty = 1, rd_level = 0, rd_ptr_gray = 0). After release, empty = 0 and rd_level = 2 at the third edge.
- Single word, default parameters:
  - Stimulus: wr_ptr_gray_i goes 0 -> 0x01. Three edges later, pulse rd_req for one cycle.
  - Required: rd_en = 1 for that cycle. At the same edge rd_addr = 1, rd_ptr_gray = 0x01, empty = 1 and rd_level = 0. underflow stays 0.
- Full occupancy: drive wr_ptr_gray_i to Gray(16) = 0x18 with rd_req = 0 -> rd_level = 16 and empty = 0. Sixteen back-to-back reads then drain it: rd_addr runs 0..15 then back to 0, and empty rises on the 16th read edge.
- Wrap-around:
  - Stimulus: stream 32 writes and reads continuously.
  - Required: rd_ptr_gray passes 0x10 (bin 31), then 0x00, with exactly one bit change per read. rd_level never goes negative and never exceeds 16.
- Underflow: with empty = 1, hold rd_req = 1 for 3 cycles -> rd_en = 0 throughout. underflow is high for 3 cycles, each lagging its request by one edge. The pointer is unchanged.
- Reset mid-stream: assert rst_n low while rd_level = 5 and rd_req = 1 -> all outputs reach reset values immediately, without waiting for a clock edge. After release the block behaves as after a fresh reset.
